mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_picker.sv | 35 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared state encoding and width defaults for mem_port_arbiter
// rev 1.0
// ============================================================================
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Index width that stays legal for a single-channel build.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : combinational winner select, round-robin from rr_ptr or fixed
// rev 1.0
// ============================================================================
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic             rr_mode,
  output logic             found,
  output logic [PTR_W-1:0] winner
);

  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    // Walk from farthest to nearest so the nearest requester overwrites last.
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = ((rr_mode ? int'(rr_ptr) : 0) + k) % N_CH;
      if (req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one slow line-memory port among N_CH miss channels
// rev 1.0
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RR_MODE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_read,
  input  logic [N_CH-1:0]          ch_write,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_wdata,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [N_CH-1:0]          ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);

  localparam int PTR_W = ptr_width(N_CH);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_CH-1:0]   ready_q, ready_d;

  logic [N_CH-1:0]   req;
  logic              pick_found;
  logic [PTR_W-1:0]  pick_idx;

  assign req = ch_read | ch_write;

  rr_picker #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .rr_mode (RR_MODE != 0),
    .found   (pick_found),
    .winner  (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    ready_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          addr_d     = ch_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d    = ch_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          // A channel raising both read and write is served as a write.
          is_write_d = ch_write[pick_idx];
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (!is_write_q) rdata_d = mem_rdata;
          ready_d[grant_q] = 1'b1;
          state_d          = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        if (RR_MODE != 0) begin
          if (int'(grant_q) == N_CH - 1) rr_ptr_d = '0;
          else                           rr_ptr_d = grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
    end
  end

  assign mem_read  = (state_q == BUSY) && !is_write_q;
  assign mem_write = (state_q == BUSY) &&  is_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ch_rdata  = rdata_q;
  assign ch_ready  = ready_q;

endmodule
`default_nettype wire
